// File: rtl/block_ce.sv
// block_ce: frame-level rate-1/2, K=3 convolutional encoder.
// An 8-bit word is captured on a start strobe and encoded MSB first.
// The encoder state is zeroed at the start of every frame.
// The resulting 2-bit symbols are packed into one codeword.
// The codeword is published in a single update together with a one-cycle o_valid pulse.
//
// Handshake: i_start is a request that is honoured only while idle (dbg_state=0).
// There is no back-pressure. o_valid is a one-cycle pulse and cannot be stalled,
// so a consumer must take o_data in the cycle o_valid is high. o_data keeps its
// value afterwards until the next frame completes.
module block_ce #(
  parameter int           SIZE_IN  = 8,
  parameter int           SIZE_OUT = 16,
  parameter logic [2:0]   G0       = 3'b111,
  parameter logic [2:0]   G1       = 3'b101
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_start,
  input  logic [SIZE_IN-1:0]  i_data,
  output logic [SIZE_OUT-1:0] o_data,
  output logic                o_valid,
  output logic                o_busy,
  output logic                dbg_state
);

  // The codeword carries exactly two symbol bits per data bit.
  if (SIZE_OUT != 2 * SIZE_IN) begin : g_bad_size
    $error("block_ce: SIZE_OUT must equal 2*SIZE_IN");
  end

  localparam int CW = $clog2(SIZE_IN) + 1;
  localparam logic [CW-1:0] LAST = CW'(SIZE_IN - 1);

  typedef enum logic {
    IDLE = 1'b0,
    ENC  = 1'b1
  } state_t;

  state_t              state;
  logic [SIZE_IN-1:0]  data_q;   // latched word, shifted left so the MSB is the next bit
  logic                s1;       // previous input bit
  logic                s2;       // input bit before s1
  logic [CW-1:0]       cnt;      // bits consumed so far in this frame
  logic [SIZE_OUT-3:0] acc;      // symbols of the frame, excluding the last one

  logic       b;
  logic [2:0] taps;
  logic       g0;
  logic       g1;

  assign dbg_state = (state == ENC);

  // Encoder taps for the bit being consumed this cycle.
  always_comb begin
    b    = data_q[SIZE_IN-1];
    taps = {b, s1, s2};
    g0   = ^(taps & G0);
    g1   = ^(taps & G1);
  end

  // Frame FSM. All outputs are registered. The final symbol joins the
  // accumulator on its way into o_data, so o_data is updated in a single step.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= IDLE;
      data_q  <= '0;
      s1      <= 1'b0;
      s2      <= 1'b0;
      cnt     <= '0;
      acc     <= '0;
      o_data  <= '0;
      o_valid <= 1'b0;
      o_busy  <= 1'b0;
    end else begin
      o_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (i_start) begin
            data_q <= i_data;
            s1     <= 1'b0;
            s2     <= 1'b0;
            cnt    <= '0;
            acc    <= '0;
            o_busy <= 1'b1;
            state  <= ENC;
          end
        end
        ENC: begin
          data_q <= {data_q[SIZE_IN-2:0], 1'b0};
          s2     <= s1;
          s1     <= b;
          cnt    <= cnt + CW'(1);
          acc    <= {acc[SIZE_OUT-5:0], g0, g1};
          if (cnt == LAST) begin
            o_data  <= {acc, g0, g1};
            o_valid <= 1'b1;
            o_busy  <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_block_ce.sv
// tb_block_ce: vector table plus hand-written corner sequences and random
// frames for block_ce. A convolution-sum reference model supplies the
// expected codewords.
module tb_block_ce;

  localparam logic [2:0] G0 = 3'b111;
  localparam logic [2:0] G1 = 3'b101;

  logic        i_clk;
  logic        i_rst_n;
  logic        i_start;
  logic [7:0]  i_data;
  logic [15:0] o_data;
  logic        o_valid;
  logic        o_busy;
  logic        dbg_state;

  int total = 0;
  int bad   = 0;

  logic [15:0] exp_q[$];

  block_ce dut (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_start  (i_start),
    .i_data   (i_data),
    .o_data   (o_data),
    .o_valid  (o_valid),
    .o_busy   (o_busy),
    .dbg_state(dbg_state)
  );

  // Clock and watchdog.
  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  initial begin
    #200us;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  // Reference model. Output bit j of symbol k is the mod-2 sum of x[k-t] over
  // the taps t that the generator enables. x is the data read MSB first, with
  // zeros before the start of the frame.
  function automatic logic [15:0] model_encode(input logic [7:0] d);
    int x [0:9];
    logic [15:0] r;
    int s0, s1v;
    x[0] = 0;
    x[1] = 0;
    for (int k = 0; k < 8; k++) x[k+2] = int'(d[7-k]);
    r = '0;
    for (int k = 0; k < 8; k++) begin
      s0 = 0;
      s1v = 0;
      for (int t = 0; t < 3; t++) begin
        if (G0[2-t]) s0  += x[k+2-t];
        if (G1[2-t]) s1v += x[k+2-t];
      end
      r[15-2*k] = (s0 % 2) == 1;
      r[14-2*k] = (s1v % 2) == 1;
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  // Caller is at a negedge. Presents a start for one cycle and then scrambles i_data.
  task automatic drive_start(input logic [7:0] d);
    i_start = 1'b1;
    i_data  = d;
    @(negedge i_clk);
    i_start = 1'b0;
    i_data  = 8'($urandom);
  endtask

  // Waits for o_valid, counting cycles and the cycles with o_busy high.
  task automatic wait_valid(output logic [15:0] data, output int lat, output int busy_n);
    lat    = 0;
    busy_n = o_busy ? 1 : 0;
    while (!o_valid && lat < 20) begin
      @(negedge i_clk);
      lat++;
      if (o_busy) busy_n++;
    end
    data = o_data;
    if (!o_valid) begin
      total++;
      bad++;
      $display("FAIL valid_timeout: no o_valid after %0d cycles", lat);
    end
  endtask

  typedef struct {
    logic [7:0]  din;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs [5];

  initial begin
    logic [15:0] got;
    int lat, busy_n, vcount, t, last_t;
    logic [7:0] d;

    vecs[0] = '{8'hB4, 16'hE14B};
    vecs[1] = '{8'h00, 16'h0000};
    vecs[2] = '{8'hFF, 16'hDAAA};
    vecs[3] = '{8'h80, 16'hEC00};
    vecs[4] = '{8'h5A, 16'h3852};

    // Reset state.
    i_rst_n = 1'b0;
    i_start = 1'b0;
    i_data  = 8'h00;
    repeat (3) @(negedge i_clk);
    check("reset_data", 32'(o_data), 32'h0);
    check("reset_valid", 32'(o_valid), 32'h0);
    check("reset_busy", 32'(o_busy), 32'h0);
    check("reset_state", 32'(dbg_state), 32'h0);
    i_rst_n = 1'b1;
    @(negedge i_clk);

    // Vector table: codeword, latency, busy duration and pulse width.
    for (int i = 0; i < 5; i++) begin
      @(negedge i_clk);
      drive_start(vecs[i].din);
      wait_valid(got, lat, busy_n);
      check($sformatf("vec%0d_data", i), 32'(got), 32'(vecs[i].exp));
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'd8);
      check($sformatf("vec%0d_busy_cycles", i), 32'(busy_n), 32'd8);
      @(negedge i_clk);
      check($sformatf("vec%0d_valid_pulse", i), 32'(o_valid), 32'h0);
      check($sformatf("vec%0d_data_hold", i), 32'(o_data), 32'(vecs[i].exp));
    end

    // Back-to-back frames with the second start in the o_valid cycle.
    @(negedge i_clk);
    drive_start(8'hFF);
    wait_valid(got, lat, busy_n);
    check("b2b_first", 32'(got), 32'hDAAA);
    drive_start(8'h80);
    wait_valid(got, lat, busy_n);
    check("b2b_second", 32'(got), 32'hEC00);
    check("b2b_latency", 32'(lat), 32'd8);

    // A start pulse and a data change in mid-frame are ignored.
    @(negedge i_clk);
    drive_start(8'hB4);
    repeat (3) @(negedge i_clk);
    i_start = 1'b1;
    i_data  = 8'h00;
    @(negedge i_clk);
    i_start = 1'b0;
    wait_valid(got, lat, busy_n);
    check("midstart_data", 32'(got), 32'hE14B);
    vcount = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge i_clk);
      if (o_valid || o_busy) vcount++;
    end
    check("midstart_no_extra", 32'(vcount), 32'd0);

    // Reset asserted in cycle 4 of a frame.
    @(negedge i_clk);
    drive_start(8'hB4);
    repeat (3) @(negedge i_clk);
    #1 i_rst_n = 1'b0;
    #1;
    check("async_rst_busy", 32'(o_busy), 32'h0);
    check("async_rst_valid", 32'(o_valid), 32'h0);
    check("async_rst_data", 32'(o_data), 32'h0);
    repeat (2) @(negedge i_clk);
    i_rst_n = 1'b1;
    vcount = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge i_clk);
      if (o_valid) vcount++;
    end
    check("abort_no_valid", 32'(vcount), 32'd0);
    drive_start(8'hB4);
    wait_valid(got, lat, busy_n);
    check("post_rst_frame", 32'(got), 32'hE14B);

    // i_start held high: one frame every 9 cycles.
    @(negedge i_clk);
    i_start = 1'b1;
    i_data  = 8'h5A;
    vcount = 0;
    last_t = -1;
    for (t = 1; t <= 30; t++) begin
      @(negedge i_clk);
      if (o_valid) begin
        vcount++;
        check("held_data", 32'(o_data), 32'h3852);
        if (last_t >= 0) check("held_period", 32'(t - last_t), 32'd9);
        last_t = t;
      end
    end
    i_start = 1'b0;
    check("held_frames", 32'(vcount), 32'd3);
    wait_valid(got, lat, busy_n);
    check("held_tail", 32'(got), 32'h3852);

    // Random frames with random idle gaps, including zero gaps.
    for (int n = 0; n < 24; n++) begin
      d = 8'($urandom);
      exp_q.push_back(model_encode(d));
      repeat ($urandom_range(0, 3)) @(negedge i_clk);
      drive_start(d);
      wait_valid(got, lat, busy_n);
      check($sformatf("rand%0d_data_%02h", n, d), 32'(got), 32'(exp_q.pop_front()));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
